audio_dma: RTL and testbench
============================

# audio_dma

Wishbone-master DMA engine that fetches stereo audio samples from system memory and streams them, one 48-bit stereo sample at a time, into the audio FIFO write port. It sits directly upstream of the audio sample FIFO and replaces CPU-driven sample writes. It is configured from register-file fields and raises a one-cycle `done` pulse for interrupt use.

## Interface

Parameters:
- `LEN_BITS`, 16: width of the sample-count configuration and the progress counter.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous reset, active-low; sampled on the rising edge of `clk`.
- `cfg_base`  in  32  byte address of the first sample; bits [1:0] are ignored and treated as 0.
- `cfg_len`  in  LEN_BITS  number of stereo samples to transfer.
- `cfg_loop`  in  1  when 1, restart from `cfg_base` after the last sample.
- `start`  in  1  single-cycle pulse; begins a transfer.
- `abort`  in  1  single-cycle pulse; stops a transfer.
- `wbm_adr_o`  out  32  Wishbone address.
- `wbm_dat_i`  in  32  Wishbone read data.
- `wbm_cyc_o`  out  1  Wishbone cycle.
- `wbm_stb_o`  out  1  Wishbone strobe.
- `wbm_we_o`  out  1  tied to 0.
- `wbm_sel_o`  out  4  tied to 4'hF.
- `wbm_ack_i`  in  1  Wishbone acknowledge.
- `wbm_err_i`  in  1  Wishbone error.
- `smp_data`  out  48  stereo sample: {left[23:0], right[23:0]}.
- `smp_valid`  out  1  `smp_data` is valid.
- `smp_ready`  in  1  FIFO accepts the sample; this is the FIFO's not-full/ready output.
- `busy`  out  1  a transfer is in progress.
- `done`  out  1  one-cycle pulse when a non-loop transfer completes.
- `error`  out  1  sticky bus-error flag; cleared by the next accepted `start`.
- `count`  out  LEN_BITS  number of samples pushed since the last start or loop restart.

## Operation

Memory layout: each sample occupies 2 words, so sample i lives at `cfg_base + 8*i`.
- The left channel is the word at offset 0; the right channel is the word at offset 4.
- Only bits [23:0] of each word are used; bits [31:24] are ignored.
- Address arithmetic is modulo 2^32.

On an accepted `start`, `cfg_base`, `cfg_len` and `cfg_loop` are latched. Config changes during a transfer have no effect.

FSM states:
- **IDLE**: `busy`=0. On `start`:
  - if the latched length is 0, pulse `done` on the next cycle and stay in IDLE with no bus traffic;
  - otherwise go to RD_L.
- **RD_L**: `cyc`=`stb`=1, `adr` = sample address. On `ack`, latch data[23:0] as left and go to RD_R; `cyc` stays high.
- **RD_R**: `adr` = sample address + 4. On `ack`, latch right, drop `cyc`/`stb`, and go to PUSH.
- **PUSH**: `smp_valid`=1, with `smp_data` held stable until `smp_valid & smp_ready`. On transfer:
  - `count` increments;
  - if `count+1 == len`:
    - with loop: reset `count` to 0 and the address to base, then go to RD_L;
    - without loop: pulse `done` and go to IDLE;
  - otherwise advance the address by 8 and go to RD_L.

Error and abort handling:
- **`wbm_err_i`** in RD_L or RD_R: drop `cyc`/`stb`, set `error`, go to IDLE. No sample is pushed and `done` is not pulsed.
- **`abort`** in any non-IDLE state: on the next edge, drop `cyc`, `stb` and `smp_valid` and go to IDLE. A partially read sample is discarded. `done` is not pulsed.
- **`start`** while `busy`=1 is ignored.
- **`abort` and `start` in the same cycle**: `abort` wins.
- **`ack` and `err` in the same cycle**: `err` wins.
- `start` and `abort` in IDLE with `cfg_len`=0: no `done` pulse.

## Timing

- Reset values (`rst`=0 at an edge):
  - `wbm_cyc_o`=0, `wbm_stb_o`=0, `wbm_adr_o`=0;
  - `smp_valid`=0, `smp_data`=0;
  - `busy`=0, `done`=0, `error`=0, `count`=0;
  - FSM in IDLE.
- Reset mid-transfer: the bus cycle is dropped immediately; no partial sample is emitted.
- `start` sampled at edge N: `cyc`/`stb`/`adr`=base are visible after edge N, and `busy`=1 from the same point.
- `ack` may arrive in the first `stb` cycle. Sampled `ack` on RD_L advances `adr` at that edge with `stb` still high (back-to-back beats, no idle cycle).
- `smp_valid` rises at the edge that samples the right-channel `ack`.
- After a push handshake at edge M, RD_L for the next sample is driven from edge M.
- Throughput: minimum 3 cycles per sample with zero-wait acks and `smp_ready`=1.
- `done` is high for exactly the cycle after the final handshake edge; `busy` falls at that same edge.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Test plan

- **Basic transfer.** Config: `cfg_base`=0x1000, `cfg_len`=3, zero-wait memory model with word k = 0xAA000000|k; pulse `start`.
  - Expected: addresses 0x1000, 0x1004, …, 0x1014.
  - `smp_data` = {24'h000000, 24'h000001}, then {…02, …03}, then {…04, …05}.
  - `done` pulses once, 1 cycle after the 3rd push; 9 cycles from `start` to last push.
- **Backpressure.** Same config, `smp_ready` held 0 for 10 cycles.
  - Expected: `smp_valid` and `smp_data` stay stable, no bus activity, and `count` stays 0 until `ready`.
- **Loop.** `cfg_len`=2, `cfg_loop`=1.
  - Expected: after the 2nd push, `adr` returns to base, `count` resets to 0, and `done` never pulses.
  - An `abort` then gives `busy`=0 and `cyc`=0 on the next edge.
- **Bus error.** `wbm_err_i` asserted on the right-channel read of sample 1.
  - Expected: `error`=1, `cyc`=0, only sample 0 pushed, no `done`.
  - A subsequent `start` clears `error`.
- **Edge cases.**
  - `cfg_len`=0 plus `start`: expect a `done` pulse the next cycle with no `cyc`.
  - `start` while busy: expect it to be ignored.
  - `cfg_base`=0xFFFFFFF8 with `cfg_len`=2: expect the 2nd sample at 0x00000000 (wrap-around).
- **Reset mid-read.** `rst`=0 while in RD_R with 3 wait states.
  - Expected: all outputs at their reset values after that edge, and no `smp_valid`.

Source files
------------

// File: rtl/audio_dma.sv
// rtl/audio_dma.sv - Wishbone-master DMA that streams stereo samples to the audio FIFO
//
// Ports:
//   clk, rst (sync, active-low)
//   cfg_base/cfg_len/cfg_loop - transfer config, latched on an accepted start
//   start, abort              - single-cycle control pulses (abort wins)
//   wbm_*                     - Wishbone read master (we=0, sel=4'hF)
//   smp_data/smp_valid/smp_ready - 48-bit {left,right} sample push to FIFO
//   busy, done, error, count  - status (all registered)

module audio_dma #(
    parameter int LEN_BITS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         cfg_base,
    input  logic [LEN_BITS-1:0] cfg_len,
    input  logic                cfg_loop,
    input  logic                start,
    input  logic                abort,
    output logic [31:0]         wbm_adr_o,
    input  logic [31:0]         wbm_dat_i,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [3:0]          wbm_sel_o,
    input  logic                wbm_ack_i,
    input  logic                wbm_err_i,
    output logic [47:0]         smp_data,
    output logic                smp_valid,
    input  logic                smp_ready,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [LEN_BITS-1:0] count
);

    typedef enum logic [1:0] {IDLE, RD_L, RD_R, PUSH} state_t;

    state_t              state_q, state_d;
    logic [31:0]         adr_q, adr_d;
    logic [31:0]         base_q, base_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic [LEN_BITS-1:0] count_q, count_d;
    logic [LEN_BITS-1:0] count_inc;
    logic                loop_q, loop_d;
    logic                cyc_q, cyc_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [47:0]         data_q, data_d;

    // Upper data byte and byte-offset address bits carry no information here.
    logic unused_bits;
    assign unused_bits = &{1'b0, wbm_dat_i[31:24], cfg_base[1:0]};

    assign count_inc = count_q + {{(LEN_BITS-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        base_d  = base_q;
        len_d   = len_q;
        loop_d  = loop_q;
        count_d = count_q;
        cyc_d   = cyc_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        error_d = error_q;
        data_d  = data_q;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    base_d  = {cfg_base[31:2], 2'b00};
                    len_d   = cfg_len;
                    loop_d  = cfg_loop;
                    error_d = 1'b0;
                    count_d = '0;
                    if (cfg_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RD_L;
                        adr_d   = {cfg_base[31:2], 2'b00};
                        cyc_d   = 1'b1;
                        busy_d  = 1'b1;
                    end
                end
            end
            RD_L: begin
                if (wbm_err_i) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end else if (wbm_ack_i) begin
                    data_d[47:24] = wbm_dat_i[23:0];
                    adr_d         = adr_q + 32'd4;
                    state_d       = RD_R;
                end
            end
            RD_R: begin
                if (wbm_err_i) begin
                    state_d = IDLE;
                    cyc_d   = 1'b0;
                    busy_d  = 1'b0;
                    error_d = 1'b1;
                end else if (wbm_ack_i) begin
                    data_d[23:0] = wbm_dat_i[23:0];
                    cyc_d        = 1'b0;
                    valid_d      = 1'b1;
                    state_d      = PUSH;
                end
            end
            PUSH: begin
                if (smp_ready) begin
                    valid_d = 1'b0;
                    if (count_inc == len_q) begin
                        if (loop_q) begin
                            count_d = '0;
                            adr_d   = base_q;
                            cyc_d   = 1'b1;
                            state_d = RD_L;
                        end else begin
                            count_d = count_inc;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else begin
                        // adr_q still points at the right word, so +4 lands on the next sample
                        count_d = count_inc;
                        adr_d   = adr_q + 32'd4;
                        cyc_d   = 1'b1;
                        state_d = RD_L;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort overrides whatever the active state decided this cycle.
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            cyc_d   = 1'b0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            error_d = error_q;
            count_d = count_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            adr_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            loop_q  <= 1'b0;
            count_q <= '0;
            cyc_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            base_q  <= base_d;
            len_q   <= len_d;
            loop_q  <= loop_d;
            count_q <= count_d;
            cyc_q   <= cyc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            data_q  <= data_d;
        end
    end

    assign wbm_adr_o = adr_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = 1'b0;
    assign wbm_sel_o = 4'hF;
    assign smp_data  = data_q;
    assign smp_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign count     = count_q;

endmodule

// File: tb/tb_audio_dma.sv
// tb/tb_audio_dma.sv - self-checking randomized bench for audio_dma

module tb_audio_dma;

    localparam int LB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   cfg_base = '0;
    logic [LB-1:0] cfg_len = '0;
    logic          cfg_loop = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [31:0]   wbm_adr_o;
    logic [31:0]   wbm_dat_i = '0;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic          wbm_ack_i = 1'b0;
    logic          wbm_err_i = 1'b0;
    logic [47:0]   smp_data;
    logic          smp_valid;
    logic          smp_ready = 1'b0;
    logic          busy;
    logic          done;
    logic          error;
    logic [LB-1:0] count;

    audio_dma #(.LEN_BITS(LB)) dut (
        .clk(clk), .rst(rst),
        .cfg_base(cfg_base), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
        .start(start), .abort(abort),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_i(wbm_dat_i), .wbm_cyc_o(wbm_cyc_o),
        .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
        .busy(busy), .done(done), .error(error), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory: word k (from mem_org) = {scrambled top byte, k}
    logic [31:0] mem_org = 32'h1000;
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] k;
        k = (a - mem_org) >> 2;
        return {8'hAA ^ a[9:2], k[23:0]};
    endfunction

    // Wishbone slave + FIFO ready generator
    int          ws_min = 0, ws_max = 0, ws_cnt = 0, ws_tgt = 0;
    bit          rdy_rand = 1'b0;
    logic        rdy_val = 1'b1;
    bit          err_en = 1'b0;
    logic [31:0] err_adr = '0;

    always @(posedge clk) begin
        #1;
        if (wbm_cyc_o === 1'b1 && wbm_stb_o === 1'b1) begin
            if (ws_cnt >= ws_tgt) begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = mem_word(wbm_adr_o);
                wbm_err_i = err_en && (wbm_adr_o == err_adr);
                ws_cnt    = 0;
                ws_tgt    = $urandom_range(ws_max, ws_min);
            end else begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
                ws_cnt++;
            end
        end else begin
            wbm_ack_i = 1'b0;
            wbm_err_i = 1'b0;
            ws_cnt    = 0;
            ws_tgt    = $urandom_range(ws_max, ws_min);
        end
        smp_ready = rdy_rand ? ($urandom_range(3, 0) != 0) : rdy_val;
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    // Reference model: transfer-level view (sample index, half, phase)
    bit          mon_en = 1'b0;
    bit          m_active = 1'b0, m_rd = 1'b0, m_h = 1'b0, m_loop = 1'b0, m_err = 1'b0;
    bit          done_due = 1'b0;
    logic [31:0] m_base = '0;
    int          m_len = 0, m_si = 0;
    int          n_push = 0, n_done = 0, start_cyc = 0, push_cyc = 0;
    logic [47:0] push_log[$];
    logic [31:0] adr_log[$];
    logic [31:0] ea, wl, wr;

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy", busy, m_active);
            check("cyc", wbm_cyc_o, m_active && m_rd);
            check("stb", wbm_stb_o, m_active && m_rd);
            check("valid", smp_valid, m_active && !m_rd);
            check("error", error, m_err);
            if (done || done_due) check("done", done, done_due);
            if (done) n_done++;
            done_due = 1'b0;
            if (!rst) begin
                m_active = 1'b0;
                m_err    = 1'b0;
            end else if (m_active) begin
                if (abort) begin
                    m_active = 1'b0;
                end else if (m_rd) begin
                    if (wbm_ack_i || wbm_err_i) begin
                        ea = m_base + 32'(m_si) * 32'd8 + (m_h ? 32'd4 : 32'd0);
                        check("adr", wbm_adr_o, ea);
                        adr_log.push_back(wbm_adr_o);
                        if (wbm_err_i) begin
                            m_active = 1'b0;
                            m_err    = 1'b1;
                        end else if (m_h) begin
                            m_h  = 1'b0;
                            m_rd = 1'b0;
                        end else begin
                            m_h = 1'b1;
                        end
                    end
                end else if (smp_ready) begin
                    ea = m_base + 32'(m_si) * 32'd8;
                    wl = mem_word(ea);
                    wr = mem_word(ea + 32'd4);
                    check("data", smp_data, {wl[23:0], wr[23:0]});
                    check("count", count, m_si);
                    push_log.push_back(smp_data);
                    n_push++;
                    push_cyc = cyc_cnt;
                    m_si++;
                    if (m_si == m_len) begin
                        if (m_loop) begin
                            m_si = 0;
                            m_rd = 1'b1;
                        end else begin
                            m_active = 1'b0;
                            done_due = 1'b1;
                        end
                    end else begin
                        m_rd = 1'b1;
                    end
                end
            end else if (start && !abort) begin
                m_base    = {cfg_base[31:2], 2'b00};
                m_len     = int'(cfg_len);
                m_loop    = cfg_loop;
                m_err     = 1'b0;
                start_cyc = cyc_cnt;
                if (cfg_len == '0) begin
                    done_due = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_rd     = 1'b1;
                    m_h      = 1'b0;
                    m_si     = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b, input int l, input bit lp);
        cfg_base = b;
        cfg_len  = l[LB-1:0];
        cfg_loop = lp;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (busy === 1'b1 && n < max_cyc) begin
            tick();
            n++;
        end
        check("idle_timeout", busy, 1'b0);
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cyc"}, wbm_cyc_o, 1'b0);
        check({tag, "_stb"}, wbm_stb_o, 1'b0);
        check({tag, "_adr"}, wbm_adr_o, 32'h0);
        check({tag, "_valid"}, smp_valid, 1'b0);
        check({tag, "_data"}, smp_data, 48'h0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_count"}, count, 16'h0);
    endtask

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int          d0, p0, n;
        logic [47:0] snap;
        logic [31:0] b;
        int          l;
        bit          lp;

        rst = 1'b0;
        tick();
        tick();
        check_reset_outputs("reset");
        check("we", wbm_we_o, 1'b0);
        check("sel", wbm_sel_o, 4'hF);
        rst    = 1'b1;
        mon_en = 1'b1;
        tick();

        // Basic transfer, zero-wait
        mem_org = 32'h1000; ws_min = 0; ws_max = 0; rdy_val = 1'b1;
        push_log.delete(); adr_log.delete(); d0 = n_done;
        do_start(32'h1000, 3, 1'b0);
        wait_idle(100);
        check("basic_npush", push_log.size(), 3);
        check("basic_nadr", adr_log.size(), 6);
        if (push_log.size() == 3) begin
            check("basic_s0", push_log[0], 48'h000000_000001);
            check("basic_s1", push_log[1], 48'h000002_000003);
            check("basic_s2", push_log[2], 48'h000004_000005);
        end
        if (adr_log.size() == 6)
            for (int i = 0; i < 6; i++) check("basic_adr", adr_log[i], 32'h1000 + 32'(i) * 4);
        check("basic_done", n_done - d0, 1);
        check("basic_latency", push_cyc - start_cyc, 9);

        // Backpressure
        rdy_val = 1'b0;
        do_start(32'h1000, 3, 1'b0);
        n = 0;
        while (smp_valid !== 1'b1 && n < 20) begin tick(); n++; end
        check("bp_valid_rise", smp_valid, 1'b1);
        snap = smp_data;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", smp_valid, 1'b1);
            check("bp_data", smp_data, snap);
            check("bp_cyc", wbm_cyc_o, 1'b0);
            check("bp_count", count, 16'd0);
        end
        rdy_val = 1'b1;
        wait_idle(100);

        // Loop then abort
        ws_max = 1; d0 = n_done; p0 = n_push;
        do_start(32'h2000, 2, 1'b1);
        n = 0;
        while (n_push - p0 < 5 && n < 200) begin tick(); n++; end
        check("loop_pushes", (n_push - p0) >= 5, 1'b1);
        check("loop_no_done", n_done - d0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 1'b0);
        check("abort_cyc", wbm_cyc_o, 1'b0);
        check("abort_valid", smp_valid, 1'b0);
        tick();

        // Bus error on right word of sample 1
        ws_max = 0; err_en = 1'b1; err_adr = 32'h300C; d0 = n_done; p0 = n_push;
        do_start(32'h3000, 3, 1'b0);
        wait_idle(100);
        err_en = 1'b0;
        check("err_flag", error, 1'b1);
        check("err_cyc", wbm_cyc_o, 1'b0);
        check("err_pushes", n_push - p0, 1);
        check("err_no_done", n_done - d0, 0);
        do_start(32'h3000, 1, 1'b0);
        check("err_clear", error, 1'b0);
        wait_idle(100);

        // Zero length
        do_start(32'h4000, 0, 1'b0);
        check("len0_done", done, 1'b1);
        check("len0_cyc", wbm_cyc_o, 1'b0);
        check("len0_busy", busy, 1'b0);
        tick();
        check("len0_done_fall", done, 1'b0);
        cfg_len = '0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("len0_abort_done", done, 1'b0);

        // Start while busy is ignored
        p0 = n_push;
        do_start(32'h5000, 4, 1'b0);
        tick();
        do_start(32'h9000, 1, 1'b0);
        wait_idle(100);
        check("busy_start_pushes", n_push - p0, 4);

        // Address wrap-around
        mem_org = 32'h0; adr_log.delete();
        do_start(32'hFFFF_FFF8, 2, 1'b0);
        wait_idle(100);
        check("wrap_nadr", adr_log.size(), 4);
        if (adr_log.size() == 4) check("wrap_adr", adr_log[2], 32'h0000_0000);

        // Reset while reading right word with 3 wait states
        ws_min = 3; ws_max = 3;
        do_start(32'h6000, 2, 1'b0);
        n = 0;
        while (!(wbm_cyc_o === 1'b1 && wbm_adr_o == 32'h6004) && n < 30) begin tick(); n++; end
        check("rr_reached", wbm_adr_o, 32'h6004);
        rst = 1'b0;
        tick();
        check_reset_outputs("rst_mid");
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rst_no_valid", smp_valid, 1'b0);
        end

        // Randomized transfers
        ws_min = 0; ws_max = 2; rdy_rand = 1'b1;
        for (int t = 0; t < 25; t++) begin
            mem_org = $urandom;
            b  = $urandom;
            l  = $urandom_range(5, 1);
            lp = ($urandom_range(3, 0) == 0);
            do_start(b, l, lp);
            if (lp) begin
                repeat ($urandom_range(40, 5)) tick();
                abort = 1'b1;
                tick();
                abort = 1'b0;
                tick();
            end else begin
                wait_idle(300);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
